// File: rtl/if_fetch_pkg.sv
// Shared constants, state encoding and address-check helper for the instruction-fetch stage.
package if_fetch_pkg;

   localparam int unsigned MEM_BYTES_IMEM    = 4096;
   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      StBoot = 2'd0,
      StRun  = 2'd1,
      StHalt = 2'd2
   } fetch_state_e;

   // Misaligned, or beyond the last full word of imem (unsigned compare).
   function automatic logic bad_addr(input logic [31:0] addr, input logic [31:0] imem_bytes);
      return (addr[1:0] != 2'b00) || (addr > (imem_bytes - 32'd4));
   endfunction

endpackage

// File: rtl/if_fetch_perf_counters.sv
// Wrapping event counters for accepted beats and back-pressured cycles.
module if_fetch_perf_counters (
   input  logic        clk,
   input  logic        rst,
   input  logic        fire,
   input  logic        stall,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count <= 32'd0;
         stall_count <= 32'd0;
      end else begin
         fetch_count <= fetch_count + {31'd0, fire};
         stall_count <= stall_count + {31'd0, stall};
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, addresses a 1-cycle-latency imem and hands
// {pc, instr, fault} beats to decode over valid/ready, with redirect and fault halt.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_BYTES = MEM_BYTES_IMEM,
   parameter logic [31:0] NOP_INSTR  = DEFAULT_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_read_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        out_fault,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
);

   localparam logic [31:0] ImemBytes = 32'(IMEM_BYTES);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q;
   logic         fault_q;
   logic         is_run;
   logic         fire;
   logic         stall;

   always_comb begin
      is_run    = (state_q == StRun);
      out_valid = is_run & ~redirect_valid;
      fire      = out_valid & out_ready;
      stall     = out_valid & ~out_ready;
      out_pc    = pc_q;
      out_fault = is_run & fault_q;
      out_instr = fault_q ? NOP_INSTR : imem_read_data;

      // Holding pc_q while stalled makes imem re-read the presented word.
      if (redirect_valid) begin
         imem_addr = redirect_pc;
      end else if (fire && !fault_q) begin
         imem_addr = pc_q + 32'd4;
      end else begin
         imem_addr = pc_q;
      end
   end

   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         state_d = StRun;
      end else begin
         unique case (state_q)
            StBoot:  state_d = StRun;
            StRun:   if (fire && fault_q) state_d = StHalt;
            StHalt:  state_d = StHalt;
            default: state_d = StBoot;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StBoot;
         pc_q    <= RESET_PC;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= imem_addr;
         fault_q <= bad_addr(imem_addr, ImemBytes);
      end
   end

   if_fetch_perf_counters u_perf (
      .clk         (clk),
      .rst         (rst),
      .fire        (fire),
      .stall       (stall),
      .fetch_count (fetch_count),
      .stall_count (stall_count)
   );

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: expected beats are queued as stimulus is driven and
// checked whenever the DUT hands a beat to decode.
module tb_if_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] imem_addr;
   logic [31:0] imem_read_data = 32'd0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_fault;
   logic [31:0] fetch_count;
   logic [31:0] stall_count;

   logic [31:0] mem [1024];
   beat_t       exp_q [$];
   int          n_cmp = 0;
   int          n_err = 0;

   if_fetch #(
      .RESET_PC   (32'h0000_0000),
      .IMEM_BYTES (4096),
      .NOP_INSTR  (NOP)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_read_data (imem_read_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_fault      (out_fault),
      .fetch_count    (fetch_count),
      .stall_count    (stall_count)
   );

   always #5 clk = ~clk;

   // Registered-read imem model; addresses past the array alias, faults mask the data anyway.
   always @(posedge clk) imem_read_data <= mem[imem_addr[11:2]];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic beat_t mk(input logic [31:0] pc, input logic fault);
      beat_t b;
      b.pc    = pc;
      b.instr = fault ? NOP : mem[pc[11:2]];
      b.fault = fault;
      return b;
   endfunction

   // Drive just after the rising edge; observe on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         beat_t e;
         check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat_pc", out_pc, e.pc);
            check("beat_instr", out_instr, e.instr);
            check("beat_fault", 32'(out_fault), 32'(e.fault));
         end
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i * 4);
      mem[0] = 32'h11;
      mem[1] = 32'h22;
      mem[2] = 32'h33;

      #2;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_pc", out_pc, 32'd0);
      check("rst_fault", 32'(out_fault), 32'd0);
      check("rst_imem_addr", imem_addr, 32'd0);
      check("rst_fetch_count", fetch_count, 32'd0);
      check("rst_stall_count", stall_count, 32'd0);

      // Boot and stream three words.
      tick(); rst = 1'b0;
      exp_q.push_back(mk(32'h0, 1'b0));
      exp_q.push_back(mk(32'h4, 1'b0));
      exp_q.push_back(mk(32'h8, 1'b0));
      mid(); check("boot_valid", 32'(out_valid), 32'd0);
      tick(); mid(); check("first_beat_valid", 32'(out_valid), 32'd1);
      tick(); mid();
      tick(); mid();
      tick(); out_ready = 1'b0;
      mid(); check("fetch_count_3", fetch_count, 32'd3);
      check("stalled_pc12", out_pc, 32'hC);

      // Redirect to 0x4 while stalled, then hold the beat for three cycles.
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h4;
      mid(); check("redir_drop_valid", 32'(out_valid), 32'd0);
      check("redir_imem_addr", imem_addr, 32'h4);
      check("redir_fetch_count", fetch_count, 32'd3);
      tick(); redirect_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mid();
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_pc", out_pc, 32'h4);
         check("stall_instr", out_instr, 32'h22);
         check("stall_imem_addr", imem_addr, 32'h4);
         if (i < 2) tick();
      end
      tick(); out_ready = 1'b1;
      exp_q.push_back(mk(32'h4, 1'b0));
      exp_q.push_back(mk(32'h8, 1'b0));
      mid(); check("stall_count_4", stall_count, 32'd4);
      tick(); mid(); check("fetch_count_4", fetch_count, 32'd4);

      // Redirect to 0x40 during a stall: dropped beat is not counted.
      tick(); out_ready = 1'b0;
      mid(); check("stall_pc12_b", out_pc, 32'hC);
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h40;
      mid(); check("redir40_valid", 32'(out_valid), 32'd0);
      check("redir40_fetch_count", fetch_count, 32'd5);
      tick(); redirect_valid = 1'b0; out_ready = 1'b1;
      exp_q.push_back(mk(32'h40, 1'b0));
      mid(); check("stall_count_5", stall_count, 32'd5);

      // Misaligned redirect: one fault beat, then halt until redirected.
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h42;
      mid(); check("redir42_valid", 32'(out_valid), 32'd0);
      tick(); redirect_valid = 1'b0;
      exp_q.push_back(mk(32'h42, 1'b1));
      mid(); check("fault_beat_valid", 32'(out_valid), 32'd1);
      tick(); mid(); check("halt_valid_a", 32'(out_valid), 32'd0);
      check("halt_imem_addr", imem_addr, 32'h42);
      tick(); mid(); check("halt_valid_b", 32'(out_valid), 32'd0);
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h0;
      mid();
      tick(); redirect_valid = 1'b0;
      exp_q.push_back(mk(32'h0, 1'b0));
      exp_q.push_back(mk(32'h4, 1'b0));
      mid(); tick(); mid();

      // Run off the end of imem.
      tick(); redirect_valid = 1'b1; redirect_pc = 32'hFF0;
      mid(); check("redirFF0_valid", 32'(out_valid), 32'd0);
      tick(); redirect_valid = 1'b0;
      for (int a = 32'hFF0; a <= 32'hFFC; a += 4) exp_q.push_back(mk(32'(a), 1'b0));
      exp_q.push_back(mk(32'h1000, 1'b1));
      for (int i = 0; i < 5; i++) begin
         mid();
         tick();
      end
      mid(); check("end_halt_valid", 32'(out_valid), 32'd0);

      // Asynchronous reset with a beat on the bus.
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h100;
      mid();
      tick(); redirect_valid = 1'b0;
      exp_q.push_back(mk(32'h100, 1'b0));
      exp_q.push_back(mk(32'h104, 1'b0));
      mid(); tick(); mid();
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_pc", out_pc, 32'd0);
      check("arst_imem_addr", imem_addr, 32'd0);
      check("arst_fetch_count", fetch_count, 32'd0);
      check("arst_stall_count", stall_count, 32'd0);
      tick(); rst = 1'b0;
      exp_q.push_back(mk(32'h0, 1'b0));
      mid(); check("reboot_valid", 32'(out_valid), 32'd0);
      tick(); mid(); check("reboot_pc", out_pc, 32'd0);
      check("reboot_valid_1", 32'(out_valid), 32'd1);
      tick(); out_ready = 1'b0;
      mid(); check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction memory and downstream of the decode stage.
- Owns the PC and drives the word address into imem; imem returns data one clock later (registered read).
- Presents {pc, instr, fault} to decode over a valid/ready handshake.
- Handles stalls, redirects (branch/jump/trap) and out-of-range/misaligned fetch faults.
- imem write_en is tied low at top level; this block never writes imem.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- IMEM_BYTES, 4096: imem size in bytes; top level sets it from `MEM_BYTES_IMEM. Last legal fetch address is IMEM_BYTES-4.
- NOP_INSTR, 32'h0000_0013: instruction substituted on a faulting beat.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- imem_addr  out  32  byte address to imem; combinational from state
- imem_read_data  in  32  imem registered read data for the address presented last cycle
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  redirect target
- out_valid  out  1  beat valid to decode
- out_ready  in  1  decode accepts the beat
- out_pc  out  32  PC of the presented beat
- out_instr  out  32  instruction of the presented beat
- out_fault  out  1  beat is a fetch fault
- fetch_count  out  32  accepted beats (wraps)
- stall_count  out  32  cycles with out_valid=1 and out_ready=0 (wraps)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All state is cleared on rst assertion without waiting for a clock edge.
- Reset values:
  - state=BOOT, pc_q=RESET_PC, fault_q=0
  - out_valid=0, out_pc=RESET_PC, out_fault=0
  - fetch_count=0, stall_count=0
  - imem_addr=RESET_PC
- States:
  - BOOT:
    - imem_addr=pc_q, out_valid=0.
    - Next edge: RUN. fault_q registers the bad-address check of pc_q.
  - RUN:
    - out_valid=!redirect_valid; out_pc=pc_q; out_fault=fault_q.
    - out_instr = fault_q ? NOP_INSTR : imem_read_data.
  - HALT:
    - out_valid=0; imem_addr=pc_q.
    - Held until redirect_valid.
- Bad address: addr[1:0]!=0, or addr > IMEM_BYTES-4 (unsigned 32-bit compare). It is computed locally; this block never inspects data for 0xFFFFFFFF.
- fire = out_valid & out_ready.
- imem_addr selection, priority order:
  - redirect_valid -> redirect_pc
  - RUN & fire & !fault_q -> pc_q+4 (mod 2^32; wrap is caught by the bound check)
  - otherwise -> pc_q
- pc_q <= imem_addr every cycle. fault_q <= bad(imem_addr). Read latency is therefore exactly one cycle.
- Stall: imem_addr is held at pc_q, so imem re-reads the same word and out_instr/out_pc stay stable while out_ready=0.
- Redirect (any state except reset):
  - The current beat is dropped: out_valid is forced 0, so no fire.
  - Next cycle: state=RUN, out_pc=redirect_pc, data valid.
  - A redirect to a bad address yields a fault beat.
- Fault: in RUN, fire with fault_q=1 -> HALT. The fault beat is presented exactly once.
- Counters:
  - fetch_count += fire.
  - stall_count += (out_valid & !out_ready).
  - Both wrap; neither is affected by redirect.
- Reset mid-stream: all outputs return to reset values asynchronously. Fetch restarts at RESET_PC via BOOT, i.e. the first beat appears 1 cycle after rst deasserts.
- Throughput: one beat per cycle while out_ready=1.

Decomposition:
- variables.vh (shared include, used as the package):
  - `MEM_BYTES_IMEM
  - `NOP_INSTR
  - state encodings BOOT=2'd0, RUN=2'd1, HALT=2'd2
- No sub-module required.
- Optional: the two counters may be split into if_perf_counters (inputs fire/stall, outputs two 32-bit counts).

Test Plan:
- Reset, then rst=0, out_ready=1, imem preloaded with words 0x11,0x22,0x33 at 0,4,8 -> cycle 1 after deassert: out_valid=1, pc=0, instr=0x11; then pc=4/0x22 and pc=8/0x33 on consecutive cycles; fetch_count=3.
- Hold out_ready=0 for 3 cycles at pc=4 -> out_pc=4, out_instr=0x22 stable; imem_addr=4; stall_count=3; resume gives pc=8 next.
- redirect_valid=1, redirect_pc=0x40 during a stall -> out_valid=0 that cycle; next cycle out_pc=0x40 with the word at 0x40; fetch_count unchanged by the dropped beat.
- redirect_pc=0x42 -> beat pc=0x42, out_fault=1, instr=0x00000013; after fire -> HALT, out_valid=0; redirect to 0x0 -> normal fetch resumes.
- Sequential run to IMEM_BYTES-4 (0xFFC) -> beat 0xFFC ok; next beat pc=0x1000 out_fault=1; then HALT.
- rst pulsed mid-stream with out_valid=1 -> out_valid=0, counters=0 immediately (asynchronously); first beat after release is pc=RESET_PC.
